// File: rtl/decode_sequencer.sv
// decode_sequencer: multi-cycle instruction sequencer.
// Latches one instruction, runs EXEC then WB, tracks flags and faults.
module decode_sequencer #(
  parameter int DATA_W   = 8,
  parameter int REG_AW   = 3,
  parameter int OP_W     = 8,
  parameter int ALU_OP_W = 5,
  parameter int STRICT   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [OP_W+2*DATA_W-1:0] instr_data,
  output logic                     gpr_w_enable,
  output logic [REG_AW-1:0]        gpr_w_addr,
  output logic [DATA_W-1:0]        gpr_w_data,
  output logic [REG_AW-1:0]        gpr_r_addr_a,
  output logic [REG_AW-1:0]        gpr_r_addr_b,
  input  logic [DATA_W-1:0]        gpr_r_data_a,
  input  logic [DATA_W-1:0]        gpr_r_data_b,
  output logic [ALU_OP_W-1:0]      alu_operation,
  output logic [DATA_W-1:0]        alu_A,
  output logic [DATA_W-1:0]        alu_B,
  input  logic [DATA_W-1:0]        alu_C,
  input  logic                     alu_carry,
  output logic                     stack_push_enable,
  output logic [DATA_W-1:0]        stack_push_data,
  output logic                     stack_pop_enable,
  input  logic [DATA_W-1:0]        stack_pop_data,
  input  logic                     stack_full,
  input  logic                     stack_empty,
  output logic                     flag_zero,
  output logic                     flag_carry,
  output logic                     retire,
  output logic                     fault
);

  localparam int IW = OP_W + 2 * DATA_W;

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(8'h00);
  localparam logic [OP_W-1:0] OP_LDR = OP_W'(8'h01);
  localparam logic [OP_W-1:0] OP_LD  = OP_W'(8'h02);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(8'h03);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(8'h04);
  localparam logic [OP_W-1:0] OP_INC = OP_W'(8'h05);
  localparam logic [OP_W-1:0] OP_DEC = OP_W'(8'h06);
  localparam logic [OP_W-1:0] OP_CLR = OP_W'(8'h07);
  localparam logic [OP_W-1:0] OP_FIL = OP_W'(8'h08);
  localparam logic [OP_W-1:0] OP_PSH = OP_W'(8'h09);
  localparam logic [OP_W-1:0] OP_POP = OP_W'(8'h0A);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_INC = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_DEC = ALU_OP_W'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB,
    S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              cp_q, cp_d;
  logic              fz_q, fz_d;
  logic              fc_q, fc_d;

  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] arg_b;
  logic [REG_AW-1:0] ra, rb;
  logic              unused_ok;

  assign op        = ir_q[IW-1 -: OP_W];
  assign arg_b     = ir_q[DATA_W-1:0];
  assign ra        = ir_q[DATA_W +: REG_AW];
  assign rb        = ir_q[0 +: REG_AW];
  assign unused_ok = ^ir_q[2*DATA_W-1:DATA_W+REG_AW];

  logic is_nop, is_ldr, is_ld, is_add, is_sub, is_inc;
  logic is_dec, is_clr, is_fil, is_psh, is_pop, is_undef;
  logic is_alu, is_skip, bad;

  // Opcode decode of the latched instruction
  always_comb begin
    is_nop   = 1'b0;
    is_ldr   = 1'b0;
    is_ld    = 1'b0;
    is_add   = 1'b0;
    is_sub   = 1'b0;
    is_inc   = 1'b0;
    is_dec   = 1'b0;
    is_clr   = 1'b0;
    is_fil   = 1'b0;
    is_psh   = 1'b0;
    is_pop   = 1'b0;
    is_undef = 1'b0;
    unique case (op)
      OP_NOP:  is_nop   = 1'b1;
      OP_LDR:  is_ldr   = 1'b1;
      OP_LD:   is_ld    = 1'b1;
      OP_ADD:  is_add   = 1'b1;
      OP_SUB:  is_sub   = 1'b1;
      OP_INC:  is_inc   = 1'b1;
      OP_DEC:  is_dec   = 1'b1;
      OP_CLR:  is_clr   = 1'b1;
      OP_FIL:  is_fil   = 1'b1;
      OP_PSH:  is_psh   = 1'b1;
      OP_POP:  is_pop   = 1'b1;
      default: is_undef = 1'b1;
    endcase
  end

  assign is_alu  = is_add | is_sub | is_inc | is_dec;
  // a lenient build treats unknown opcodes as NOP
  assign is_skip = is_nop | (is_undef && STRICT == 0);
  assign bad     = (is_pop && stack_empty)
                 | (is_psh && stack_full)
                 | (is_undef && STRICT != 0);

  assign instr_ready = (state_q == S_IDLE) || (state_q == S_WB);

  // Next-state, instruction latch, result and flag update
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    res_d   = res_q;
    cp_d    = cp_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        if (is_alu) begin
          res_d = alu_C;
          cp_d  = alu_carry;
        end
        if (is_ld)  res_d = gpr_r_data_a;
        if (is_ldr) res_d = arg_b;
        if (is_clr) res_d = '0;
        if (is_fil) res_d = '1;
        if (is_pop) res_d = stack_pop_data;
        if (is_skip || is_psh) state_d = S_IDLE;
        if (bad) state_d = S_FAULT;
      end
      S_WB: begin
        if (is_alu) begin
          fz_d = (res_q == '0);
          fc_d = cp_q;
        end
        state_d = S_IDLE;
        if (instr_valid) begin
          ir_d    = instr_data;
          state_d = S_EXEC;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      res_q   <= '0;
      cp_q    <= 1'b0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
      cp_q    <= cp_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
    end
  end

  assign flag_zero  = fz_q;
  assign flag_carry = fc_q;
  assign fault      = (state_q == S_FAULT);

  // Strobes, addresses and operands for the EXEC and WB cycles
  always_comb begin
    gpr_w_enable      = 1'b0;
    gpr_w_addr        = '0;
    gpr_w_data        = '0;
    gpr_r_addr_a      = '0;
    gpr_r_addr_b      = '0;
    alu_operation     = '0;
    alu_A             = '0;
    alu_B             = '0;
    stack_push_enable = 1'b0;
    stack_push_data   = '0;
    stack_pop_enable  = 1'b0;
    retire            = 1'b0;
    if (state_q == S_EXEC) begin
      if (is_ld) gpr_r_addr_a = rb;
      if (is_alu || is_psh) gpr_r_addr_a = ra;
      if (is_add || is_sub) gpr_r_addr_b = rb;
      if (is_alu) begin
        alu_A = gpr_r_data_a;
        if (is_add || is_sub) alu_B = gpr_r_data_b;
        unique case (1'b1)
          is_add: alu_operation = ALU_ADD;
          is_sub: alu_operation = ALU_SUB;
          is_inc: alu_operation = ALU_INC;
          default: alu_operation = ALU_DEC;
        endcase
      end
      if (is_pop && !stack_empty) stack_pop_enable = 1'b1;
      if (is_psh && !stack_full) begin
        stack_push_enable = 1'b1;
        stack_push_data   = gpr_r_data_a;
      end
      retire = is_skip || (is_psh && !stack_full);
    end
    if (state_q == S_WB) begin
      gpr_w_enable = 1'b1;
      gpr_w_addr   = ra;
      gpr_w_data   = res_q;
      retire       = 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: directed bench with GPR, ALU and stack models.
// Opcode and ALU encodings match the decoder's instruction set.
module tb_decode_sequencer;

  localparam logic [7:0] NOP = 8'h00, LDR = 8'h01, LD = 8'h02;
  localparam logic [7:0] ADD = 8'h03, SUB = 8'h04, INC = 8'h05;
  localparam logic [7:0] DEC = 8'h06, CLR = 8'h07, FIL = 8'h08;
  localparam logic [7:0] PSH = 8'h09, POP = 8'h0A;

  logic clk = 1'b0;
  logic rst;
  logic instr_valid;
  logic instr_ready;
  logic [23:0] instr_data;
  logic gpr_w_enable;
  logic [2:0] gpr_w_addr, gpr_r_addr_a, gpr_r_addr_b;
  logic [7:0] gpr_w_data, gpr_r_data_a, gpr_r_data_b;
  logic [4:0] alu_operation;
  logic [7:0] alu_A, alu_B, alu_C;
  logic alu_carry;
  logic stack_push_enable, stack_pop_enable;
  logic [7:0] stack_push_data, stack_pop_data;
  logic stack_full, stack_empty;
  logic flag_zero, flag_carry, retire, fault;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data),
    .gpr_w_enable(gpr_w_enable), .gpr_w_addr(gpr_w_addr),
    .gpr_w_data(gpr_w_data),
    .gpr_r_addr_a(gpr_r_addr_a), .gpr_r_addr_b(gpr_r_addr_b),
    .gpr_r_data_a(gpr_r_data_a), .gpr_r_data_b(gpr_r_data_b),
    .alu_operation(alu_operation), .alu_A(alu_A), .alu_B(alu_B),
    .alu_C(alu_C), .alu_carry(alu_carry),
    .stack_push_enable(stack_push_enable),
    .stack_push_data(stack_push_data),
    .stack_pop_enable(stack_pop_enable),
    .stack_pop_data(stack_pop_data),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .flag_zero(flag_zero), .flag_carry(flag_carry),
    .retire(retire), .fault(fault)
  );

  // peripheral models
  logic [7:0] gpr [8];
  logic [7:0] stk [8];
  int sp;
  logic ovr_full = 1'b0;

  assign gpr_r_data_a = gpr[gpr_r_addr_a];
  assign gpr_r_data_b = gpr[gpr_r_addr_b];
  assign stack_empty = (sp == 0);
  assign stack_full = ovr_full || (sp == 4);
  assign stack_pop_data = (sp == 0) ? 8'h00 : stk[sp-1];

  always_comb begin
    logic [8:0] s;
    s = 9'h0;
    case (alu_operation)
      5'd0: s = {1'b0, alu_A} + {1'b0, alu_B};
      5'd1: s = {1'b0, alu_A} - {1'b0, alu_B};
      5'd2: s = {1'b0, alu_A} + 9'd1;
      5'd3: s = {1'b0, alu_A} - 9'd1;
      default: s = 9'h0;
    endcase
    alu_C = s[7:0];
    alu_carry = s[8];
  end

  int cyc = 0;
  int nacc = 0, nw = 0, nret = 0, npush = 0, npop = 0;
  int acyc [64];
  int wcyc [64];
  int rcyc [64];
  logic [2:0] wadr [64];
  logic [7:0] wdat [64];
  logic [7:0] last_push;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 8; i++) gpr[i] <= 8'h00;
      sp <= 0;
    end else begin
      if (instr_valid && instr_ready) begin
        acyc[nacc] <= cyc;
        nacc <= nacc + 1;
      end
      if (gpr_w_enable) begin
        gpr[gpr_w_addr] <= gpr_w_data;
        wcyc[nw] <= cyc;
        wadr[nw] <= gpr_w_addr;
        wdat[nw] <= gpr_w_data;
        nw <= nw + 1;
      end
      if (retire) begin
        rcyc[nret] <= cyc;
        nret <= nret + 1;
      end
      if (stack_push_enable) begin
        stk[sp] <= stack_push_data;
        sp <= sp + 1;
        last_push <= stack_push_data;
        npush <= npush + 1;
      end
      if (stack_pop_enable) begin
        sp <= sp - 1;
        npop <= npop + 1;
      end
    end
  end

  task automatic send(input logic [7:0] op, input logic [7:0] a,
                      input logic [7:0] b);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_data = {op, a, b};
    for (int i = 0; i < 8 && !instr_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_valid = 1'b1;
    instr_data = {LDR, 8'h01, 8'h77};
    repeat (3) @(negedge clk);
    n_chk++;
    if (instr_ready !== 1'b1 || fault !== 1'b0 || retire !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b fault=%b retire=%b want 1 0 0",
               instr_ready, fault, retire);
    end
    n_chk++;
    if (gpr_w_enable !== 1'b0 || stack_push_enable !== 1'b0 ||
        stack_pop_enable !== 1'b0 || alu_A !== 8'h00 ||
        gpr_w_addr !== 3'd0 || alu_operation !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_out: we=%b push=%b pop=%b aluA=%h wa=%0d aop=%0d want 0",
               gpr_w_enable, stack_push_enable, stack_pop_enable,
               alu_A, gpr_w_addr, alu_operation);
    end
    n_chk++;
    if (flag_zero !== 1'b0 || flag_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: z=%b c=%b want 0 0", flag_zero, flag_carry);
    end
    rst = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (instr_ready !== 1'b1 || nacc !== 0) begin
      n_fail++;
      $display("FAIL reset_wins: ready=%b accepts=%0d want 1 0",
               instr_ready, nacc);
    end
  endtask

  task automatic test_load();
    int a0, w0, r0;
    a0 = nacc; w0 = nw; r0 = nret;
    send(LDR, 8'h02, 8'h5A);
    send(LD, 8'h05, 8'h02);
    n_chk++;
    if (nw !== w0 + 2 || wadr[w0] !== 3'd2 || wdat[w0] !== 8'h5A ||
        wadr[w0+1] !== 3'd5 || wdat[w0+1] !== 8'h5A) begin
      n_fail++;
      $display("FAIL load_writes: n=%0d w0=r%0d:%h w1=r%0d:%h want 2 r2:5a r5:5a",
               nw - w0, wadr[w0], wdat[w0], wadr[w0+1], wdat[w0+1]);
    end
    n_chk++;
    if (wcyc[w0] - acyc[a0] !== 2 || wcyc[w0+1] - acyc[a0+1] !== 2) begin
      n_fail++;
      $display("FAIL load_latency: %0d %0d want 2 2",
               wcyc[w0] - acyc[a0], wcyc[w0+1] - acyc[a0+1]);
    end
    n_chk++;
    if (nret !== r0 + 2 || rcyc[r0] - acyc[a0] !== 2 ||
        rcyc[r0+1] - acyc[a0+1] !== 2) begin
      n_fail++;
      $display("FAIL load_retire: n=%0d lat=%0d want 2 2",
               nret - r0, rcyc[r0] - acyc[a0]);
    end
  endtask

  task automatic test_add_flags();
    send(LDR, 8'h01, 8'hF0);
    send(LDR, 8'h03, 8'h10);
    n_chk++;
    if (flag_zero !== 1'b0 || flag_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL ldr_keeps_flags: z=%b c=%b want 0 0",
               flag_zero, flag_carry);
    end
    send(ADD, 8'h01, 8'h03);
    n_chk++;
    if (gpr[1] !== 8'h00 || flag_zero !== 1'b1 || flag_carry !== 1'b1) begin
      n_fail++;
      $display("FAIL add_wrap: r1=%h z=%b c=%b want 00 1 1",
               gpr[1], flag_zero, flag_carry);
    end
    send(LDR, 8'h04, 8'h99);
    send(CLR, 8'h04, 8'h00);
    n_chk++;
    if (gpr[4] !== 8'h00 || flag_zero !== 1'b1 || flag_carry !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_flags: r4=%h z=%b c=%b want 00 1 1",
               gpr[4], flag_zero, flag_carry);
    end
  endtask

  task automatic test_dec_inc();
    send(LDR, 8'h00, 8'h00);
    send(DEC, 8'h00, 8'h00);
    n_chk++;
    if (gpr[0] !== 8'hFF || flag_zero !== 1'b0 || flag_carry !== 1'b1) begin
      n_fail++;
      $display("FAIL dec_zero: r0=%h z=%b c=%b want ff 0 1",
               gpr[0], flag_zero, flag_carry);
    end
    send(INC, 8'h00, 8'h00);
    n_chk++;
    if (gpr[0] !== 8'h00 || flag_zero !== 1'b1 || flag_carry !== 1'b1) begin
      n_fail++;
      $display("FAIL inc_wrap: r0=%h z=%b c=%b want 00 1 1",
               gpr[0], flag_zero, flag_carry);
    end
  endtask

  task automatic test_sub_fil();
    send(FIL, 8'hFA, 8'h00);
    n_chk++;
    if (gpr[2] !== 8'hFF) begin
      n_fail++;
      $display("FAIL fil_index: r2=%h want ff", gpr[2]);
    end
    send(LDR, 8'h03, 8'h01);
    send(SUB, 8'h02, 8'h03);
    n_chk++;
    if (gpr[2] !== 8'hFE || flag_zero !== 1'b0 || flag_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL sub: r2=%h z=%b c=%b want fe 0 0",
               gpr[2], flag_zero, flag_carry);
    end
    send(NOP, 8'h02, 8'h00);
    n_chk++;
    if (gpr[2] !== 8'hFE || fault !== 1'b0 || instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL nop: r2=%h fault=%b ready=%b want fe 0 1",
               gpr[2], fault, instr_ready);
    end
  endtask

  task automatic test_stack();
    int w0, a0, r0, p0, q0;
    send(LDR, 8'h02, 8'h33);
    w0 = nw; a0 = nacc; r0 = nret; p0 = npush; q0 = npop;
    send(PSH, 8'h02, 8'h00);
    n_chk++;
    if (npush !== p0 + 1 || last_push !== 8'h33 || nw !== w0) begin
      n_fail++;
      $display("FAIL push: pulses=%0d data=%h writes=%0d want 1 33 0",
               npush - p0, last_push, nw - w0);
    end
    n_chk++;
    if (nret !== r0 + 1 || rcyc[r0] - acyc[a0] !== 1) begin
      n_fail++;
      $display("FAIL push_retire: n=%0d lat=%0d want 1 1",
               nret - r0, rcyc[r0] - acyc[a0]);
    end
    send(POP, 8'h06, 8'h00);
    n_chk++;
    if (npop !== q0 + 1 || gpr[6] !== 8'h33 || sp !== 0) begin
      n_fail++;
      $display("FAIL pop: pulses=%0d r6=%h sp=%0d want 1 33 0",
               npop - q0, gpr[6], sp);
    end
  endtask

  task automatic test_fault_pop();
    int q0, a0, w0;
    q0 = npop;
    send(POP, 8'h07, 8'h00);
    a0 = nacc; w0 = nw;
    n_chk++;
    if (fault !== 1'b1 || instr_ready !== 1'b0 || npop !== q0) begin
      n_fail++;
      $display("FAIL pop_empty: fault=%b ready=%b pops=%0d want 1 0 0",
               fault, instr_ready, npop - q0);
    end
    instr_valid = 1'b1;
    instr_data = {LDR, 8'h01, 8'h11};
    repeat (4) @(negedge clk);
    n_chk++;
    if (fault !== 1'b1 || instr_ready !== 1'b0 || nacc !== a0 ||
        nw !== w0) begin
      n_fail++;
      $display("FAIL fault_hold: fault=%b ready=%b acc=%0d wr=%0d want 1 0 0 0",
               fault, instr_ready, nacc - a0, nw - w0);
    end
    do_reset();
    n_chk++;
    if (fault !== 1'b0 || instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_clear: fault=%b ready=%b want 0 1",
               fault, instr_ready);
    end
  endtask

  task automatic test_push_full();
    int p0;
    p0 = npush;
    ovr_full = 1'b1;
    send(PSH, 8'h00, 8'h00);
    n_chk++;
    if (fault !== 1'b1 || npush !== p0) begin
      n_fail++;
      $display("FAIL push_full: fault=%b pushes=%0d want 1 0",
               fault, npush - p0);
    end
    ovr_full = 1'b0;
    do_reset();
  endtask

  task automatic test_undef();
    int w0;
    w0 = nw;
    send(8'hFF, 8'h01, 8'h02);
    n_chk++;
    if (fault !== 1'b1 || nw !== w0) begin
      n_fail++;
      $display("FAIL undef: fault=%b writes=%0d want 1 0", fault, nw - w0);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [7:0] val [4];
    int a0, w0, k;
    logic acc;
    val[0] = 8'h11; val[1] = 8'h22; val[2] = 8'h33; val[3] = 8'h44;
    send(LDR, 8'h01, 8'hF0);
    send(LDR, 8'h03, 8'h10);
    send(ADD, 8'h01, 8'h03);
    a0 = nacc; w0 = nw; k = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_data = {LDR, 8'h01, val[0]};
    for (int t = 0; t < 40 && k < 4; t++) begin
      acc = instr_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        if (k < 4) instr_data = {LDR, 8'(k + 1), val[k]};
      end
    end
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (nacc !== a0 + 4 || acyc[a0+1] - acyc[a0] !== 2 ||
        acyc[a0+2] - acyc[a0+1] !== 2 || acyc[a0+3] - acyc[a0+2] !== 2) begin
      n_fail++;
      $display("FAIL b2b_accept: n=%0d gaps=%0d %0d %0d want 4 2 2 2",
               nacc - a0, acyc[a0+1] - acyc[a0],
               acyc[a0+2] - acyc[a0+1], acyc[a0+3] - acyc[a0+2]);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (wcyc[w0+i] - acyc[a0+i] !== 2 || wdat[w0+i] !== val[i] ||
          wadr[w0+i] !== 3'(i + 1)) begin
        n_fail++;
        $display("FAIL b2b_write%0d: lat=%0d r%0d=%h want 2 r%0d=%h",
                 i, wcyc[w0+i] - acyc[a0+i], wadr[w0+i], wdat[w0+i],
                 i + 1, val[i]);
      end
    end
    n_chk++;
    if (flag_zero !== 1'b1 || flag_carry !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_flags: z=%b c=%b want 1 1", flag_zero, flag_carry);
    end
    w0 = nw; k = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_data = {LDR, 8'h05, 8'h55};
    for (int t = 0; t < 40 && k < 3; t++) begin
      acc = instr_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        if (k < 3) instr_data = {LDR, 8'(k + 5), 8'(8'h55 + 8'(k) * 8'h11)};
      end
    end
    rst = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (nw !== w0 + 2 || gpr_w_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_exec: writes=%0d we=%b want 2 0",
               nw - w0, gpr_w_enable);
    end
    n_chk++;
    if (flag_zero !== 1'b0 || flag_carry !== 1'b0 || fault !== 1'b0 ||
        instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_state: z=%b c=%b fault=%b ready=%b want 0 0 0 1",
               flag_zero, flag_carry, fault, instr_ready);
    end
  endtask

  initial begin
    instr_valid = 1'b0;
    instr_data = 24'h0;
    rst = 1'b1;
    test_reset();
    test_load();
    test_add_flags();
    test_dec_inc();
    test_sub_fil();
    test_stack();
    test_fault_pop();
    test_push_full();
    test_undef();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
